motion_mode_encoder: RTL
========================

// Module: motion_mode_encoder
// PURPOSE
//  Produces the 3-bit motion_mode code consumed by the 7-segment motion indicator.
//  Classifies the Rojobot wheel-control byte (left/right direction + speed) into
//  STOP / RIGHT_1x / RIGHT_2x / LEFT_1x / LEFT_2x / FORWARD / REVERSE.
//  A prescaled sample tick and a hold filter stop the indicator animation from
//  flickering on transient wheel commands. Sits between the bot interface and the
//  indicator FSM.
// PARAMETERS
//  SAMPLE_DIV     2_000_000  clk cycles per sample tick (1 = every cycle); min 1
//  HOLD_SAMPLES   3          consecutive identical samples before commit; min 1
//  TURN2X_THRESH  8          |vL-vR| >= this selects the *_2x turn code
//  STRAIGHT_TOL   0          |vL-vR| <= this counts as straight/stop
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-low reset
//  motctl        in   8   [7]=L dir (1=rev), [6:4]=L speed, [3]=R dir, [2:0]=R speed
//  motion_mode   out  3   committed mode code (registered)
//  mode_chg      out  1   1-cycle pulse on the cycle motion_mode changes
//  change_count  out  16  committed-change counter (see CONFIGURATION)
// BEHAVIOUR
//  Codes: STOP=000 RIGHT_1x=001 RIGHT_2x=010 LEFT_1x=011 LEFT_2x=100 FORWARD=101
//   REVERSE=110; 111 is never driven.
//  Reset (async, immediate): motion_mode=STOP, mode_chg=0, change_count=0,
//   cand=STOP, cnt=0, prescaler=0, state=SETTLED.
//  Prescaler counts 0..SAMPLE_DIV-1; tick=1 in the cycle it equals SAMPLE_DIV-1,
//   then it wraps to 0.
//  Classify (combinational on motctl):
//   vL/vR = signed 4-bit, +speed if dir=0 else -speed.
//   d = vL-vR and s = vL+vR, both 5-bit signed, no overflow possible.
//   |d|<=STRAIGHT_TOL: s>0 FORWARD, s<0 REVERSE, s==0 STOP.
//   d>0: RIGHT_2x if d>=TURN2X_THRESH else RIGHT_1x.
//   d<0: LEFT_2x if -d>=TURN2X_THRESH else LEFT_1x.
//   Dir bit with speed 0 means velocity 0, so 8'h88 classifies as STOP.
//  Filter, acting on tick cycles only:
//   c==cand: cnt <= min(cnt+1, HOLD_SAMPLES).
//   c!=cand: cand <= c, cnt <= 1.
//  FSM:
//   SETTLED (cand==motion_mode): go to PENDING when cand!=motion_mode.
//   PENDING: in the cycle after cnt==HOLD_SAMPLES with cand!=motion_mode,
//    motion_mode<=cand, mode_chg<=1 for 1 cycle, go to SETTLED.
//   If cand reverts to motion_mode before commit: no pulse, go to SETTLED.
//  Latency: a change first sampled on tick k commits 1 cycle after tick k+HOLD-1.
//  No tick in a cycle: cand and cnt hold.
//  Reset mid-PENDING: the pending change is discarded and no pulse is issued.
// CONFIGURATION
//  MOTION_STATS_EN defined: change_count increments on each mode_chg pulse,
//   saturates at 16'hFFFF, and is cleared only by reset.
//  MOTION_STATS_EN undefined: change_count is tied to 16'h0000 and no counter is built.
// STRUCTURE
//  Package motion_defs: 3-bit mode codes, motctl field positions, FSM state encoding.
//  Sub-module motion_classify: pure combinational motctl->code, reused by the bench model.
//  Top holds the prescaler, filter, FSM and optional stats counter.
// TESTING
//  All scenarios use SAMPLE_DIV=4, HOLD_SAMPLES=3, defaults otherwise.
//  1 reset low mid-run, including mid-PENDING
//    -> motion_mode=000, mode_chg=0, change_count=0 immediately.
//  2 motctl=8'h33 held
//    -> motion_mode=101 one cycle after the 3rd tick; exactly one mode_chg pulse.
//  3 8'h70 -> 001; 8'h7F -> 010; 8'hF7 -> 100; 8'h07 -> 011.
//    Each is held for 3 ticks.
//  4 8'h33 for 2 ticks, then 8'h00
//    -> motion_mode stays 000; mode_chg never asserts.
//  5 8'hBB -> 110; 8'h88 -> 000; 8'h3B -> 001 (d=6 < 8).
//  6 three committed changes: MOTION_STATS_EN defined -> change_count=3;
//    undefined -> 0.

Source files
------------

// File: rtl/motion_mode_encoder_pkg.sv
// Shared definitions for the motion mode encoder: indicator mode codes,
// motctl field positions and the commit FSM state encoding.
package motion_defs;

  // 3-bit codes understood by the 7-segment motion indicator; 3'b111 is unused
  typedef enum logic [2:0] {
    MODE_STOP     = 3'b000,
    MODE_RIGHT_1X = 3'b001,
    MODE_RIGHT_2X = 3'b010,
    MODE_LEFT_1X  = 3'b011,
    MODE_LEFT_2X  = 3'b100,
    MODE_FORWARD  = 3'b101,
    MODE_REVERSE  = 3'b110
  } mode_t;

  // Rojobot wheel-control byte layout
  localparam int L_DIR_BIT = 7;
  localparam int L_SPD_MSB = 6;
  localparam int L_SPD_LSB = 4;
  localparam int R_DIR_BIT = 3;
  localparam int R_SPD_MSB = 2;
  localparam int R_SPD_LSB = 0;

  typedef enum logic {
    ST_SETTLED = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Signed wheel velocity: reverse direction negates the speed, so a set
  // direction bit with zero speed is still zero velocity
  function automatic logic signed [3:0] wheel_velocity(input logic dir,
                                                       input logic [2:0] speed);
    logic signed [3:0] mag;
    mag = $signed({1'b0, speed});
    return dir ? -mag : mag;
  endfunction

endpackage

// File: rtl/motion_mode_encoder_if.sv
// Bot-side bus of the motion mode encoder: wheel-control byte in, committed
// indicator mode, change pulse and change counter out.
interface motion_mode_encoder_if;
  logic [7:0]  motctl;
  logic [2:0]  motion_mode;
  logic        mode_chg;
  logic [15:0] change_count;

  modport master (output motctl, input motion_mode, mode_chg, change_count);
  modport slave  (input motctl, output motion_mode, mode_chg, change_count);
endinterface

// File: rtl/motion_mode_encoder_classify.sv
// Pure combinational classifier: turns the wheel-control byte into an
// indicator mode from the difference and sum of the signed wheel velocities.
module motion_classify
  import motion_defs::*;
#(
  parameter int TURN2X_THRESH = 8,
  parameter int STRAIGHT_TOL  = 0
) (
  input  logic [7:0] motctl,
  output mode_t      mode
);

  localparam logic [4:0] THRESH_MAG = 5'(TURN2X_THRESH);
  localparam logic [4:0] TOL_MAG    = 5'(STRAIGHT_TOL);

  logic signed [3:0] vel_l;
  logic signed [3:0] vel_r;
  logic signed [4:0] diff;
  logic signed [4:0] sum;
  logic [4:0]        diff_mag;

  // Straight motion when the wheels nearly agree, otherwise turn toward the slower wheel
  always_comb begin
    vel_l    = wheel_velocity(motctl[L_DIR_BIT], motctl[L_SPD_MSB:L_SPD_LSB]);
    vel_r    = wheel_velocity(motctl[R_DIR_BIT], motctl[R_SPD_MSB:R_SPD_LSB]);
    diff     = {vel_l[3], vel_l} - {vel_r[3], vel_r};
    sum      = {vel_l[3], vel_l} + {vel_r[3], vel_r};
    diff_mag = diff[4] ? (~diff + 5'd1) : diff;
    mode     = MODE_STOP;
    if (diff_mag <= TOL_MAG) begin
      if (sum == 5'sd0) begin
        mode = MODE_STOP;
      end else if (sum[4]) begin
        mode = MODE_REVERSE;
      end else begin
        mode = MODE_FORWARD;
      end
    end else if (!diff[4]) begin
      mode = (diff_mag >= THRESH_MAG) ? MODE_RIGHT_2X : MODE_RIGHT_1X;
    end else begin
      mode = (diff_mag >= THRESH_MAG) ? MODE_LEFT_2X : MODE_LEFT_1X;
    end
  end

endmodule

// File: rtl/motion_mode_encoder.sv
// Motion mode encoder top: samples the classified wheel command on a
// prescaled tick, requires HOLD_SAMPLES identical samples before committing
// a new indicator mode, and pulses mode_chg on each commit.
// Optional feature: define MOTION_STATS_EN to build the saturating
// committed-change counter; otherwise change_count reads as zero.
module motion_mode_encoder
  import motion_defs::*;
#(
  parameter int SAMPLE_DIV    = 2_000_000,
  parameter int HOLD_SAMPLES  = 3,
  parameter int TURN2X_THRESH = 8,
  parameter int STRAIGHT_TOL  = 0
) (
  input logic                 clk,
  input logic                 reset,
  motion_mode_encoder_if.slave bus
);

  localparam int PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_SAMPLES);

  logic [PRE_W-1:0] prescaler;
  logic             tick;
  mode_t            sample_mode;
  mode_t            cand;
  logic [CNT_W-1:0] cnt;
  mode_t            motion_mode_q;
  logic             mode_chg_q;
  state_t           state;
  state_t           state_next;
  logic             commit;

  motion_classify #(
    .TURN2X_THRESH(TURN2X_THRESH),
    .STRAIGHT_TOL (STRAIGHT_TOL)
  ) u_classify (
    .motctl(bus.motctl),
    .mode  (sample_mode)
  );

  assign tick = (prescaler == PRE_LAST);

  // Free-running sample prescaler, tick on its last count then wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Hold filter: count consecutive identical samples of the current candidate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand <= MODE_STOP;
      cnt  <= '0;
    end else if (tick) begin
      if (sample_mode == cand) begin
        if (cnt != HOLD_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cand <= sample_mode;
        cnt  <= CNT_W'(1);
      end
    end
  end

  // Commit decision: a differing candidate that has been held long enough is taken
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      ST_SETTLED: begin
        if (cand != motion_mode_q) begin
          if (cnt == HOLD_MAX) begin
            commit = 1'b1;
          end else begin
            state_next = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (cand == motion_mode_q) begin
          state_next = ST_SETTLED;
        end else if (cnt == HOLD_MAX) begin
          commit     = 1'b1;
          state_next = ST_SETTLED;
        end
      end
      default: state_next = ST_SETTLED;
    endcase
  end

  // State register plus the committed mode and its one-cycle change pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_SETTLED;
      motion_mode_q <= MODE_STOP;
      mode_chg_q    <= 1'b0;
    end else begin
      state      <= state_next;
      mode_chg_q <= commit;
      if (commit) begin
        motion_mode_q <= cand;
      end
    end
  end

  assign bus.motion_mode = motion_mode_q;
  assign bus.mode_chg    = mode_chg_q;

`ifdef MOTION_STATS_EN
  logic [15:0] change_count_q;

  // Saturating count of committed mode changes, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_count_q <= 16'h0000;
    end else if (commit && (change_count_q != 16'hFFFF)) begin
      change_count_q <= change_count_q + 16'd1;
    end
  end

  assign bus.change_count = change_count_q;
`else
  assign bus.change_count = 16'h0000;
`endif

endmodule
